// File: rtl/pipeline_pkg.sv
// Shared RV32 pipeline definitions: default datapath width, writeback-select encodings
// and the MEM-stage load/store unit state type.
package pipeline_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble loads an all-zero entry (no register write);
// otherwise the MEM-stage results advance to writeback every cycle.
module mem_wb_reg
    import pipeline_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      rd_addr,
    input  logic            reg_write_en,
    input  logic [1:0]      mem_to_reg,
    output logic [XLEN-1:0] wb_pc_plus_4,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_reg_write_en,
    output logic [1:0]      wb_mem_to_reg
);

    logic [XLEN-1:0] pc_plus_4_r;
    logic [XLEN-1:0] alu_result_r;
    logic [XLEN-1:0] mem_data_r;
    logic [4:0]      rd_addr_r;
    logic            reg_write_en_r;
    logic [1:0]      mem_to_reg_r;

    // MEM/WB capture or bubble insertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_plus_4_r    <= {XLEN{1'b0}};
            alu_result_r   <= {XLEN{1'b0}};
            mem_data_r     <= {XLEN{1'b0}};
            rd_addr_r      <= 5'd0;
            reg_write_en_r <= 1'b0;
            mem_to_reg_r   <= 2'b00;
        end else if (bubble) begin
            pc_plus_4_r    <= {XLEN{1'b0}};
            alu_result_r   <= {XLEN{1'b0}};
            mem_data_r     <= {XLEN{1'b0}};
            rd_addr_r      <= 5'd0;
            reg_write_en_r <= 1'b0;
            mem_to_reg_r   <= 2'b00;
        end else begin
            pc_plus_4_r    <= pc_plus_4;
            alu_result_r   <= alu_result;
            mem_data_r     <= mem_data;
            rd_addr_r      <= rd_addr;
            reg_write_en_r <= reg_write_en;
            mem_to_reg_r   <= mem_to_reg;
        end
    end

    assign wb_pc_plus_4    = pc_plus_4_r;
    assign wb_alu_result   = alu_result_r;
    assign wb_mem_data     = mem_data_r;
    assign wb_rd_addr      = rd_addr_r;
    assign wb_reg_write_en = reg_write_en_r;
    assign wb_mem_to_reg   = mem_to_reg_r;

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory handshake, upstream stall, timeout abort
// and MEM/WB register. Build macro LSU_MISALIGN_CHECK_EN rejects accesses with address bits [1:0] != 0.
module mem_stage_lsu
    import pipeline_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] mem_pc_plus_4_i,
    input  logic [XLEN-1:0] mem_alu_result_i,
    input  logic [XLEN-1:0] mem_read_data2_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic            mem_reg_write_en_i,
    input  logic [1:0]      mem_mem_to_reg_i,
    input  logic            mem_mem_read_en_i,
    input  logic            mem_mem_write_en_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic            bus_err_o,
    output logic [XLEN-1:0] wb_pc_plus_4_o,
    output logic [XLEN-1:0] wb_alu_result_o,
    output logic [XLEN-1:0] wb_mem_data_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic            wb_reg_write_en_o,
    output logic [1:0]      wb_mem_to_reg_o
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    lsu_state_t      state_r;
    lsu_state_t      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic            we_r;

    logic            access_s;
    logic            misalign_s;
    logic            timeout_s;
    logic            latch_s;
    logic            stall_s;
    logic            bus_err_s;
    logic            bubble_s;
    logic [XLEN-1:0] wb_data_s;
    logic            wb_we_s;

    assign access_s = mem_mem_read_en_i | mem_mem_write_en_i;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign_s = (mem_alu_result_i[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // The last REQ/WAIT cycle aborts; the request is withdrawn in that cycle so no late grant lands
    assign timeout_s = (state_r != IDLE) && (cnt_r == CNT_LAST);

    // Next-state, counter and stall/bubble/error decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        stall_s     = 1'b0;
        bus_err_s   = 1'b0;
        bubble_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (access_s && misalign_s) begin
                    bus_err_s = 1'b1;
                    bubble_s  = 1'b1;
                end else if (access_s) begin
                    latch_s     = 1'b1;
                    stall_s     = 1'b1;
                    bubble_s    = 1'b1;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (timeout_s) begin
                    bus_err_s   = 1'b1;
                    bubble_s    = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (dmem_gnt_i && we_r) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (dmem_gnt_i) begin
                    stall_s     = 1'b1;
                    bubble_s    = 1'b1;
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end else begin
                    stall_s   = 1'b1;
                    bubble_s  = 1'b1;
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            WAIT: begin
                // Data returning on the final cycle still completes the load
                if (dmem_rvalid_i) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (timeout_s) begin
                    bus_err_s   = 1'b1;
                    bubble_s    = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    stall_s   = 1'b1;
                    bubble_s  = 1'b1;
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
                bubble_s    = 1'b1;
            end
        endcase
    end

    // Load data only reaches MEM/WB from a WAIT completion; everything else carries zero
    always_comb begin
        wb_data_s = {XLEN{1'b0}};
        if (state_r == WAIT) begin
            wb_data_s = dmem_rdata_i;
        end else begin
            wb_data_s = {XLEN{1'b0}};
        end
    end

    assign wb_we_s = mem_reg_write_en_i & ~mem_mem_write_en_i;

    // FSM state and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Data-memory address/data/direction, held stable for the whole access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= {XLEN{1'b0}};
            wdata_r <= {XLEN{1'b0}};
            we_r    <= 1'b0;
        end else if (latch_s) begin
            addr_r  <= mem_alu_result_i;
            wdata_r <= mem_read_data2_i;
            we_r    <= mem_mem_write_en_i;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            we_r    <= we_r;
        end
    end

    assign dmem_req_o   = (state_r == REQ) && !timeout_s;
    assign dmem_we_o    = we_r;
    assign dmem_addr_o  = addr_r;
    assign dmem_wdata_o = wdata_r;
    assign stall_o      = stall_s;
    assign bus_err_o    = bus_err_s;

    mem_wb_reg #(
        .XLEN (XLEN)
    ) u_mem_wb_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .bubble          (bubble_s),
        .pc_plus_4       (mem_pc_plus_4_i),
        .alu_result      (mem_alu_result_i),
        .mem_data        (wb_data_s),
        .rd_addr         (mem_rd_addr_i),
        .reg_write_en    (wb_we_s),
        .mem_to_reg      (mem_mem_to_reg_i),
        .wb_pc_plus_4    (wb_pc_plus_4_o),
        .wb_alu_result   (wb_alu_result_o),
        .wb_mem_data     (wb_mem_data_o),
        .wb_rd_addr      (wb_rd_addr_o),
        .wb_reg_write_en (wb_reg_write_en_o),
        .wb_mem_to_reg   (wb_mem_to_reg_o)
    );

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit of the 5-stage RV32 pipeline. It consumes the EX/MEM register outputs and runs a req/gnt/rvalid handshake to data memory for LW/SW. It stalls the upstream pipeline while an access is outstanding. It contains the MEM/WB pipeline register that feeds writeback.

Parameters:
XLEN, 32, datapath width
TIMEOUT_CYCLES, 64, maximum cycles spent in REQ+WAIT before an access is aborted (must be >=2)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
mem_pc_plus_4_i  in  XLEN  PC+4 from EX/MEM
mem_alu_result_i  in  XLEN  ALU result / effective address
mem_read_data2_i  in  XLEN  store data
mem_rd_addr_i  in  5  destination register
mem_reg_write_en_i  in  1  register write enable
mem_mem_to_reg_i  in  2  writeback select: 00 ALU, 01 MEM, 10 PC+4
mem_mem_read_en_i  in  1  load
mem_mem_write_en_i  in  1  store
dmem_req_o  out  1  access request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  XLEN  word address (alu_result)
dmem_wdata_o  out  XLEN  store data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  XLEN  read data
stall_o  out  1  hold PC/IF/ID/EX/EX-MEM this cycle
bus_err_o  out  1  one-cycle pulse on timeout (or misalign)
wb_pc_plus_4_o, wb_alu_result_o, wb_mem_data_o  out  XLEN each  MEM/WB data
wb_rd_addr_o  out  5;  wb_reg_write_en_o  out  1;  wb_mem_to_reg_o  out  2  MEM/WB controls

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0. dmem_req_o/dmem_we_o/bus_err_o/stall_o = 0. dmem_addr_o, dmem_wdata_o and all wb_* outputs = 0. A mid-access reset drops dmem_req_o immediately. A late rvalid arriving after reset is ignored.
- access = mem_mem_read_en_i | mem_mem_write_en_i. If both are set, the store wins and no writeback occurs (wb_reg_write_en_o=0).
- FSM:
  - IDLE: if access, latch addr, wdata and we into the dmem_* registers, go to REQ. stall_o=1.
  - REQ: dmem_req_o=1, address and data held stable. On gnt: a store completes; a load goes to WAIT. rvalid is ignored in REQ.
  - WAIT: dmem_req_o=0. On rvalid, the load completes.
- Completion cycle: stall_o=0 and the state returns to IDLE. EX/MEM advances on the same edge. MEM/WB captures the inputs with wb_mem_data_o = dmem_rdata_i (load) or 0 (store).
- stall_o is combinational: 1 whenever an access is pending and not completing this cycle.
- While stall_o=1, MEM/WB loads a bubble: wb_reg_write_en_o=0, all other wb_* = 0.
- Non-access instruction: no stall; MEM/WB captures a pass-through every cycle with wb_mem_data_o = 0.
- Latency: non-memory 1 cycle. SW with gnt on the first REQ cycle stalls 1 cycle. LW with gnt then rvalid on the next cycle stalls 2 cycles.
- Timeout: the counter increments every cycle in REQ/WAIT and clears on completion. When it reaches TIMEOUT_CYCLES-1 without completion:
  - drop the request and pulse bus_err_o for that cycle;
  - complete with wb_reg_write_en_o=0 and wb_mem_data_o=0; return to IDLE.
- Back-to-back accesses: each re-enters via IDLE, so there is a minimum 1-cycle gap between dmem_req_o pulses.

Optional Feature:
LSU_MISALIGN_CHECK_EN.
- Defined: in IDLE, an access with mem_alu_result_i[1:0]!=0 never raises dmem_req_o. It pulses bus_err_o, stalls 0 cycles, and writes a bubble (wb_reg_write_en_o=0) to MEM/WB.
- Undefined: low address bits are ignored and the access proceeds normally.

Decomposition:
- Shared package pipeline_pkg: XLEN default, the MEM_TO_REG encodings (WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10), and the lsu_state_t enum (IDLE, REQ, WAIT).
- One sub-module: mem_wb_reg, holding the MEM/WB flops with a bubble input driven by stall_o, timeout or misalign. FSM and counter stay in mem_stage_lsu.

Test Plan:
- Reset then ADDI pass-through: alu=0x0F, rd=2, reg_write=1, mem_to_reg=00 → no stall; next edge wb_alu_result_o=0x0F, wb_rd_addr_o=2, wb_reg_write_en_o=1.
- SW addr=0x0, data=0x14, gnt on first REQ cycle → dmem_req_o=1, dmem_we_o=1, wdata=0x14 for 1 cycle; stall_o high exactly 1 cycle; wb_reg_write_en_o=0.
- LW rd=5 addr=0x0, gnt after 2 REQ cycles, rvalid 3 cycles later with rdata=0x14 → stall_o high 6 cycles; then wb_mem_data_o=0x14, wb_rd_addr_o=5, wb_mem_to_reg_o=01; one bubble per stall cycle.
- LW with no rvalid, TIMEOUT_CYCLES=4 → bus_err_o pulses once 4 cycles after entering REQ; stall drops; wb_reg_write_en_o=0; FSM back to IDLE.
- rst_n low while in WAIT, then rvalid arrives → dmem_req_o=0 and all wb_*=0 immediately; the stray rvalid causes no writeback.
- With LSU_MISALIGN_CHECK_EN defined: LW addr=0x2 → no dmem_req_o, bus_err_o pulses 1 cycle, no stall, wb_reg_write_en_o=0.
